// File: rtl/core_pkg.sv
// Core-wide types shared by the execute, writeback and ROB logic.
// wb_entry_t is the completion record carried from execute units into the ROB.
package core_pkg;

  localparam int ROB_ENTRIES = 32;
  localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [31:0]          val;
    logic                 br_mispred;
    logic                 exception;
  } wb_entry_t;

endpackage

// File: rtl/wb_channel_fifo.sv
// Single-channel completion FIFO; head is visible the cycle after a push, pop is same-cycle.
// full refuses push even while popping; flush empties it and drops that cycle's push.
module wb_channel_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_data,
  output logic      full,
  input  logic      pop,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/execute_writeback_arbiter.sv
// Buffers NUM_EX execute completions and round-robin grants up to WB_PORTS per cycle to the ROB.
// Push-to-writeback latency 2 cycles; per-channel ready drops when its FIFO is full, no output backpressure.
module execute_writeback_arbiter
  import core_pkg::*;
#(
  parameter int NUM_EX     = 4,
  parameter int WB_PORTS   = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_EX-1:0]                   ex_valid,
  output logic [NUM_EX-1:0]                   ex_ready,
  input  logic [NUM_EX-1:0][ROB_IDX_W-1:0]    ex_rob_idx,
  input  logic [NUM_EX-1:0][31:0]             ex_val,
  input  logic [NUM_EX-1:0]                   ex_br_mispred,
  input  logic [NUM_EX-1:0]                   ex_exception,
  output logic [WB_PORTS-1:0]                 wb_valid,
  output logic [WB_PORTS-1:0][ROB_IDX_W-1:0]  wb_rob_idx,
  output logic [WB_PORTS-1:0][31:0]           wb_val,
  output logic [WB_PORTS-1:0]                 wb_br_mispred,
  output logic [WB_PORTS-1:0]                 wb_exception
);

  localparam int CH_W = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;
  localparam int PW   = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

  logic [NUM_EX-1:0]   full;
  logic [NUM_EX-1:0]   empty;
  logic [NUM_EX-1:0]   pop;
  wb_entry_t           head [NUM_EX];
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     rr_nxt;
  logic [WB_PORTS-1:0] gnt_vld;
  logic [CH_W-1:0]     gnt_ch [WB_PORTS];
  wb_entry_t           gnt_head [WB_PORTS];
  logic [WB_PORTS-1:0] wb_load;

  assign ex_ready = ~full;

  for (genvar i = 0; i < NUM_EX; i++) begin : g_ch
    wb_entry_t push_entry;
    assign push_entry = '{rob_idx: ex_rob_idx[i], val: ex_val[i],
                          br_mispred: ex_br_mispred[i], exception: ex_exception[i]};
    wb_channel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (ex_valid[i]),
      .push_data (push_entry),
      .full      (full[i]),
      .pop       (pop[i]),
      .empty     (empty[i]),
      .head      (head[i])
    );
  end

  // Scan from rr_ptr; the n-th non-empty channel found goes to port n.
  always_comb begin : arb_scan
    int n;
    int c;
    n       = 0;
    c       = 0;
    pop     = '0;
    gnt_vld = '0;
    rr_nxt  = rr_ptr;
    for (int k = 0; k < WB_PORTS; k++) gnt_ch[k] = '0;
    for (int j = 0; j < NUM_EX; j++) begin
      c = int'(rr_ptr) + j;
      if (c >= NUM_EX) c = c - NUM_EX;
      if (!empty[CH_W'(c)] && n < WB_PORTS) begin
        pop[CH_W'(c)]    = 1'b1;
        gnt_vld[PW'(n)]  = 1'b1;
        gnt_ch[PW'(n)]   = CH_W'(c);
        rr_nxt           = CH_W'((c + 1) % NUM_EX);
        n                = n + 1;
      end
    end
  end

  for (genvar k = 0; k < WB_PORTS; k++) begin : g_port
    assign gnt_head[k] = head[gnt_ch[k]];
  end

  assign wb_load = gnt_vld & {WB_PORTS{!flush}};

  // Ungranted ports keep their old data fields; only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      wb_valid      <= '0;
      wb_rob_idx    <= '0;
      wb_val        <= '0;
      wb_br_mispred <= '0;
      wb_exception  <= '0;
    end else begin
      if (!flush) rr_ptr <= rr_nxt;
      wb_valid <= wb_load;
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_load[k]) begin
          wb_rob_idx[k]    <= gnt_head[k].rob_idx;
          wb_val[k]        <= gnt_head[k].val;
          wb_br_mispred[k] <= gnt_head[k].br_mispred;
          wb_exception[k]  <= gnt_head[k].exception;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_writeback_arbiter.sv
// Directed plus randomized bench for execute_writeback_arbiter against a queue-based reference model.
module tb_execute_writeback_arbiter;
  import core_pkg::*;

  localparam int NUM_EX     = 4;
  localparam int WB_PORTS   = 2;
  localparam int FIFO_DEPTH = 2;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  logic [NUM_EX-1:0]                  ex_valid = '0;
  logic [NUM_EX-1:0]                  ex_ready;
  logic [NUM_EX-1:0][ROB_IDX_W-1:0]   ex_rob_idx = '0;
  logic [NUM_EX-1:0][31:0]            ex_val = '0;
  logic [NUM_EX-1:0]                  ex_br_mispred = '0;
  logic [NUM_EX-1:0]                  ex_exception = '0;
  logic [WB_PORTS-1:0]                wb_valid;
  logic [WB_PORTS-1:0][ROB_IDX_W-1:0] wb_rob_idx;
  logic [WB_PORTS-1:0][31:0]          wb_val;
  logic [WB_PORTS-1:0]                wb_br_mispred;
  logic [WB_PORTS-1:0]                wb_exception;

  execute_writeback_arbiter #(
    .NUM_EX(NUM_EX), .WB_PORTS(WB_PORTS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rob_idx(ex_rob_idx),
    .ex_val(ex_val), .ex_br_mispred(ex_br_mispred), .ex_exception(ex_exception),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_val(wb_val),
    .wb_br_mispred(wb_br_mispred), .wb_exception(wb_exception)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  wb_entry_t           m_q [NUM_EX][$];
  int                  m_rr;
  logic [WB_PORTS-1:0] m_vld;
  wb_entry_t           m_dat [WB_PORTS];
  logic [NUM_EX-1:0]   last_acc;
  int                  got [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_entry_t dut_port(input int k);
    return '{rob_idx: wb_rob_idx[k], val: wb_val[k],
             br_mispred: wb_br_mispred[k], exception: wb_exception[k]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_EX; i++) m_q[i].delete();
    m_rr  = 0;
    m_vld = '0;
    for (int k = 0; k < WB_PORTS; k++) m_dat[k] = '0;
  endtask

  // One clock edge of the spec: grants over pre-edge queue contents, then accepted pushes.
  task automatic model_step();
    int sz [NUM_EX];
    int n;
    int last;
    n    = 0;
    last = -1;
    for (int i = 0; i < NUM_EX; i++) sz[i] = m_q[i].size();
    if (flush) begin
      for (int i = 0; i < NUM_EX; i++) m_q[i].delete();
      m_vld = '0;
    end else begin
      for (int j = 0; j < NUM_EX; j++) begin
        int c;
        c = (m_rr + j) % NUM_EX;
        if (sz[c] > 0 && n < WB_PORTS) begin
          m_dat[n] = m_q[c].pop_front();
          n++;
          last = c;
        end
      end
      for (int k = 0; k < WB_PORTS; k++) m_vld[k] = (k < n);
      if (last >= 0) m_rr = (last + 1) % NUM_EX;
      for (int i = 0; i < NUM_EX; i++)
        if (ex_valid[i] && sz[i] < FIFO_DEPTH)
          m_q[i].push_back('{rob_idx: ex_rob_idx[i], val: ex_val[i],
                             br_mispred: ex_br_mispred[i], exception: ex_exception[i]});
    end
  endtask

  task automatic tick();
    #1;
    for (int i = 0; i < NUM_EX; i++)
      check($sformatf("ex_ready[%0d]", i), 64'(ex_ready[i]), 64'(m_q[i].size() < FIFO_DEPTH));
    last_acc = ex_valid & ex_ready;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check("wb_valid", 64'(wb_valid), 64'(m_vld));
    for (int k = 0; k < WB_PORTS; k++)
      check($sformatf("wb_port%0d", k), 64'(dut_port(k)), 64'(m_dat[k]));
    check("rr_ptr", 64'(dut.rr_ptr), 64'(m_rr));
  endtask

  task automatic set_ch(input int i, input logic v, input logic [ROB_IDX_W-1:0] idx,
                        input logic [31:0] val, input logic mis, input logic exc);
    ex_valid[i]      = v;
    ex_rob_idx[i]    = idx;
    ex_val[i]        = val;
    ex_br_mispred[i] = mis;
    ex_exception[i]  = exc;
  endtask

  task automatic rand_ch(input int i, input int lo, input int hi);
    set_ch(i, 1'b1, ROB_IDX_W'($urandom_range(hi, lo)), $urandom,
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
  endtask

  task automatic clear_inputs();
    ex_valid = '0;
    flush    = 1'b0;
  endtask

  task automatic collect();
    for (int k = 0; k < WB_PORTS; k++)
      if (wb_valid[k] && wb_rob_idx[k] >= 10 && wb_rob_idx[k] <= 13)
        got.push_back(int'(wb_rob_idx[k]));
  endtask

  initial begin
    int base;
    int p;
    int seen_nr;
    int marker;
    model_reset();
    clear_inputs();
    #2 rst = 1'b1;
    #10;
    check("reset_wb_valid", 64'(wb_valid), 64'(0));
    check("reset_ex_ready", 64'(ex_ready), 64'(4'hF));
    check("reset_rr_ptr", 64'(dut.rr_ptr), 64'(0));
    check("reset_wb_val0", 64'(wb_val[0]), 64'(0));
    rst = 1'b0;
    for (int t = 0; t < 3; t++) tick();

    // Fairness: every channel pushes every cycle, rob_idx tags the channel.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NUM_EX; i++) set_ch(i, 1'b1, ROB_IDX_W'(i), $urandom, 1'b0, 1'b0);
      tick();
      if (n >= 1) begin
        base = ((n - 1) % 2) * 2;
        check("fair_vld", 64'(wb_valid), 64'(2'b11));
        check("fair_p0", 64'(wb_rob_idx[0]), 64'(base));
        check("fair_p1", 64'(wb_rob_idx[1]), 64'(base + 1));
      end
    end
    clear_inputs();
    for (int t = 0; t < 5; t++) tick();

    // Single push on channel 2.
    set_ch(2, 1'b1, ROB_IDX_W'(5), 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    clear_inputs();
    check("single_c1_vld", 64'(wb_valid), 64'(0));
    tick();
    check("single_vld", 64'(wb_valid), 64'(2'b01));
    check("single_rob", 64'(wb_rob_idx[0]), 64'(5));
    check("single_val", 64'(wb_val[0]), 64'(32'hDEADBEEF));
    tick();
    check("single_c3_vld", 64'(wb_valid), 64'(0));

    // Backpressure: channel 0 producer holds each item until accepted.
    for (int t = 0; t < 2; t++) begin
      for (int i = 1; i < NUM_EX; i++) rand_ch(i, 16, 31);
      tick();
    end
    p = 0;
    seen_nr = 0;
    got.delete();
    for (int t = 0; t < 40 && p < 4; t++) begin
      set_ch(0, 1'b1, ROB_IDX_W'(10 + p), 32'hB000_0000 + 32'(p), 1'b0, 1'b1);
      for (int i = 1; i < NUM_EX; i++) rand_ch(i, 16, 31);
      tick();
      if (last_acc[0]) p++;
      else seen_nr = 1;
      collect();
    end
    clear_inputs();
    for (int t = 0; t < 6; t++) begin
      tick();
      collect();
    end
    check("bp_all_pushed", 64'(p), 64'(4));
    check("bp_not_ready_seen", 64'(seen_nr), 64'(1));
    check("bp_count", 64'(got.size()), 64'(4));
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("bp_order%0d", i), 64'(got[i]), 64'(10 + i));

    // Flush with full FIFOs and valid outputs.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NUM_EX; i++) rand_ch(i, 16, 30);
      tick();
    end
    check("pre_flush_vld", 64'(wb_valid), 64'(2'b11));
    flush = 1'b1;
    for (int i = 0; i < NUM_EX; i++) set_ch(i, 1'b1, ROB_IDX_W'(31), 32'hF1F1F1F1, 1'b0, 1'b0);
    tick();
    check("flush_vld", 64'(wb_valid), 64'(0));
    clear_inputs();
    #1;
    check("flush_ready", 64'(ex_ready), 64'(4'hF));
    marker = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      for (int k = 0; k < WB_PORTS; k++)
        if (wb_valid[k] && wb_rob_idx[k] == ROB_IDX_W'(31)) marker++;
    end
    check("flush_marker", 64'(marker), 64'(0));

    // Randomized traffic with occasional flushes.
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < NUM_EX; i++)
        if ($urandom_range(2, 0) != 0) rand_ch(i, 0, 31);
        else ex_valid[i] = 1'b0;
      flush = ($urandom_range(15, 0) == 0);
      tick();
    end

    // Asynchronous reset between edges.
    clear_inputs();
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NUM_EX; i++) rand_ch(i, 0, 31);
      tick();
    end
    clear_inputs();
    check("arst_pre_vld", 64'(wb_valid), 64'(2'b11));
    #3 rst = 1'b1;
    #1;
    check("arst_vld", 64'(wb_valid), 64'(0));
    check("arst_ready", 64'(ex_ready), 64'(4'hF));
    check("arst_rr", 64'(dut.rr_ptr), 64'(0));
    model_reset();
    tick();
    #2 rst = 1'b0;
    set_ch(1, 1'b1, ROB_IDX_W'(7), 32'h1234_5678, 1'b1, 1'b0);
    tick();
    clear_inputs();
    check("post_rst_c1_vld", 64'(wb_valid), 64'(0));
    tick();
    check("post_rst_vld", 64'(wb_valid), 64'(2'b01));
    check("post_rst_rob", 64'(wb_rob_idx[0]), 64'(7));
    check("post_rst_val", 64'(wb_val[0]), 64'(32'h1234_5678));
    check("post_rst_mis", 64'(wb_br_mispred[0]), 64'(1));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_writeback_arbiter.md
# execute_writeback_arbiter

Collects completion results from NUM_EX execute units and delivers up to WB_PORTS of them per cycle to the reorder buffer's writeback ports. It sits between the execute stage and the ROB and replaces the single execute-to-ROB channel with a multi-channel, buffered, backpressured path. It adds round-robin fairness and a global flush. Each completion carries a ROB index, a 32-bit result, a branch-mispredict flag and an exception flag.

## Interface

Parameters:
- NUM_EX, 4, number of execute-side input channels (≥1).
- WB_PORTS, 2, number of ROB writeback ports (1 ≤ WB_PORTS ≤ NUM_EX).
- FIFO_DEPTH, 2, entries per input channel FIFO (power of two, ≥2).

Ports (clock and reset: one clock; reset is asynchronous and active-high; ROB_IDX_W = $clog2(ROB_ENTRIES)):
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush from the ROB; discards all buffered and in-flight completions.
- ex_valid  in  [NUM_EX]  channel i presents a completion.
- ex_ready  out  [NUM_EX]  channel i FIFO can accept.
- ex_rob_idx  in  [NUM_EX][ROB_IDX_W]  ROB entry of the completion.
- ex_val  in  [NUM_EX][32]  result value.
- ex_br_mispred  in  [NUM_EX]  branch mispredicted.
- ex_exception  in  [NUM_EX]  instruction raised an exception.
- wb_valid  out  [WB_PORTS]  writeback port k valid this cycle.
- wb_rob_idx  out  [WB_PORTS][ROB_IDX_W]  ROB entry written.
- wb_val  out  [WB_PORTS][32]  result.
- wb_br_mispred  out  [WB_PORTS]  mispredict flag.
- wb_exception  out  [WB_PORTS]  exception flag.

## Operation

- Push: channel i is accepted when ex_valid[i] && ex_ready[i]. ex_ready[i] = !full[i], derived from FIFO count only. No pass-through: a full FIFO refuses a push even in a cycle where it pops.
- Arbitration: each cycle, scan channels rr_ptr, rr_ptr+1, … (mod NUM_EX). The first WB_PORTS channels with a non-empty FIFO are granted in scan order: the first goes to port 0, the second to port 1, and so on. Each granted FIFO pops its head.
- rr_ptr update: rr_ptr becomes (last granted channel + 1) mod NUM_EX. It is unchanged when no channel is granted. rr_ptr resets to 0.
- Output: wb_* are registered. On each edge, port k loads the granted head. Ungranted ports load wb_valid=0, and their data fields hold their previous value.
- The ROB always accepts writebacks; there is no output backpressure.
- Flags pass through unmodified; mispredict/exception entries receive no priority.
- Flush: a cycle with flush=1 has the following effect at the next edge:
  - all FIFOs are emptied;
  - all wb_valid are cleared;
  - any push presented that cycle is dropped;
  - rr_ptr is held.
  - ex_ready stays driven from the pre-flush count during the flush cycle.
- Reset values: wb_valid=0, wb_rob_idx=0, wb_val=0, wb_br_mispred=0, wb_exception=0, all FIFOs empty (so ex_ready all 1 after reset), rr_ptr=0. Reset mid-operation discards everything immediately and asynchronously.

## Timing

- Latency: a completion pushed in cycle t into an empty FIFO is eligible for arbitration in cycle t+1 and appears on wb_* in cycle t+2, assuming it wins arbitration.
- Throughput: each channel sustains 1 completion per cycle when granted every cycle. The aggregate limit is WB_PORTS per cycle.
- Simultaneous push and pop on a non-full FIFO: both occur, and the count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by a count of width $clog2(FIFO_DEPTH)+1.
- Starvation bound: a non-empty channel is granted within ceil(NUM_EX/WB_PORTS) cycles.

## Structure

- ROB_ENTRIES comes from CORE_PKG. CORE_PKG gains a packed typedef wb_entry_t = {rob_idx, val[31:0], br_mispred, exception} shared with the ROB writeback logic.
- Sub-module wb_channel_fifo: single-channel FIFO of wb_entry_t, parameter DEPTH. Ports: push/full, pop/empty/head, flush.
- The top level contains the NUM_EX FIFO instances, the combinational multi-grant round-robin scan, rr_ptr, and the output registers.

## Test plan

- Reset then idle: all wb_valid=0, all ex_ready=1, rr_ptr=0.
- Single push: channel 2 pushes rob_idx=5, val=0xDEADBEEF in cycle 0 -> wb_valid[0]=1 in cycle 2 with rob_idx=5, val=0xDEADBEEF; wb_valid[1]=0.
- Fairness: with defaults, all 4 channels push every cycle -> grants go {0,1}, then {2,3}, then {0,1} on ports {0,1}; each channel receives exactly 1 grant every 2 cycles.
- Backpressure: channel 0 pushes 3 consecutive completions while channels 1–3 keep winning arbitration (pre-filled) -> ex_ready[0]=0 once the FIFO holds 2. The third push is held by the producer and accepted after the first pop; no entry is lost or reordered.
- Flush: 2 entries buffered per channel and outputs valid, flush=1 for one cycle -> next cycle all wb_valid=0 and all ex_ready=1. The push presented during the flush never appears on wb_*.
- Async reset mid-stream: assert rst between clock edges -> wb_valid drops to 0 immediately. After release, the first new push appears 2 cycles later.
